pc_next_ctrl: RTL and testbench

Next-PC controller that sits directly upstream of the PC register. Each cycle it drives the register's `pc_src`/`ext_addr` pair, selecting between sequential advance (PC+2), hold on stall, a taken branch, return-from-interrupt, and a multi-cycle interrupt entry sequence that fetches the handler address from a vector word in data memory. It also produces the IF/ID flush and keeps the saved return address (EPC).

---
 rtl/pc_next_ctrl_if.sv | 29 ++
 rtl/pc_next_ctrl.sv | 110 +++++++++++
 tb/tb_pc_next_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_next_ctrl_if.sv
// Bundle between the next-PC controller and its fetch/execute/data-memory neighbours.
// The controller takes the slave modport; whoever drives pc/stall/branch/etc. takes master.
interface pc_next_ctrl_if;
    logic [31:0] pc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        rti;
    logic        int_req;
    logic [31:0] dmem_rdata;
    logic        pc_src;
    logic [31:0] ext_addr;
    logic        flush;
    logic        dmem_rd;
    logic [31:0] dmem_addr;
    logic        int_ack;
    logic [31:0] epc;
    logic        align_err;

    modport master (
        output pc, stall, br_taken, br_target, rti, int_req, dmem_rdata,
        input  pc_src, ext_addr, flush, dmem_rd, dmem_addr, int_ack, epc, align_err
    );

    modport slave (
        input  pc, stall, br_taken, br_target, rti, int_req, dmem_rdata,
        output pc_src, ext_addr, flush, dmem_rd, dmem_addr, int_ack, epc, align_err
    );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC select, IF/ID flush, EPC and 3-cycle vectored interrupt entry.
// Optional: PC_CTRL_ALIGN_CHK_EN forces redirect bit0 low and flags align_err.
module pc_next_ctrl #(
    parameter logic [31:0] INT_VECTOR_ADDR = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    pc_next_ctrl_if.slave b
);
    typedef enum logic [1:0] {RUN, INT_RD, INT_JMP} state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        int_en_q, int_en_d;

    logic        pc_src;
    logic [31:0] raw_addr;
    logic        int_accept;

    // Interrupts are only taken on a clean cycle: no branch, no rti, no stall.
    assign int_accept = !b.br_taken && !b.rti && b.int_req && int_en_q && !b.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            epc_q    <= 32'h0;
            int_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            int_en_q <= int_en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        int_en_d = int_en_q;
        case (state_q)
            RUN: begin
                if (!b.br_taken && b.rti) begin
                    int_en_d = 1'b1;
                end else if (int_accept) begin
                    epc_d    = b.pc;
                    int_en_d = 1'b0;
                    state_d  = INT_RD;
                end
            end
            INT_RD:  state_d = INT_JMP;
            INT_JMP: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_src      = 1'b0;
        raw_addr    = 32'h0;
        b.flush     = 1'b0;
        b.dmem_rd   = 1'b0;
        b.dmem_addr = 32'h0;
        b.int_ack   = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (b.br_taken) begin
                        pc_src   = 1'b1;
                        raw_addr = b.br_target;
                        b.flush  = 1'b1;
                    end else if (b.rti) begin
                        pc_src   = 1'b1;
                        raw_addr = epc_q;
                        b.flush  = 1'b1;
                    end else if (int_accept) begin
                        pc_src   = 1'b1;
                        raw_addr = b.pc;
                        b.flush  = 1'b1;
                    end else if (b.stall) begin
                        pc_src   = 1'b1;
                        raw_addr = b.pc;
                    end
                end
                INT_RD: begin
                    pc_src      = 1'b1;
                    raw_addr    = epc_q;
                    b.flush     = 1'b1;
                    b.dmem_rd   = 1'b1;
                    b.dmem_addr = INT_VECTOR_ADDR;
                end
                INT_JMP: begin
                    pc_src    = 1'b1;
                    raw_addr  = b.dmem_rdata;
                    b.flush   = 1'b1;
                    b.int_ack = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign b.pc_src = pc_src;
    assign b.epc    = epc_q;

`ifdef PC_CTRL_ALIGN_CHK_EN
    assign b.ext_addr  = pc_src ? {raw_addr[31:1], 1'b0} : raw_addr;
    assign b.align_err = pc_src & raw_addr[0];
`else
    assign b.ext_addr  = raw_addr;
    assign b.align_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl with a behavioural PC register closing the loop.
module tb_pc_next_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_next_ctrl_if bus();

    pc_next_ctrl #(.INT_VECTOR_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .b     (bus.slave)
    );

    always #5 clk = ~clk;

    // PC register model: forced load for test setup, else follows the controller.
    logic [31:0] pcr = 32'h0;
    logic        pc_set = 1'b0;
    logic [31:0] pc_set_val = 32'h0;
    always @(posedge clk) begin
        if (pc_set)          pcr <= pc_set_val;
        else if (bus.pc_src) pcr <= bus.ext_addr;
        else                 pcr <= pcr + 32'd2;
    end
    assign bus.pc = pcr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_set = 1'b1; pc_set_val = v;
        tick();
        pc_set = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.br_taken = 0; bus.br_target = 0; bus.rti = 0;
        bus.int_req = 0; bus.dmem_rdata = 0;

        // Reset for two cycles
        reset = 1; pc_set = 1; pc_set_val = 32'h20;
        bus.int_req = 1; bus.br_taken = 1; bus.br_target = 32'h44;
        tick(); tick();
        #1;
        chk("rst_pc_src", bus.pc_src, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_dmem_rd", bus.dmem_rd, 0);
        chk("rst_ext", bus.ext_addr, 0);
        bus.int_req = 0; bus.br_taken = 0; bus.br_target = 0;
        reset = 0; pc_set = 0;
        #1;
        chk("rst_epc", bus.epc, 0);
        chk("idle_pc_src", bus.pc_src, 0);
        chk("pc20", pcr, 32'h20);
        tick(); chk("pc22", pcr, 32'h22);
        tick(); chk("pc24", pcr, 32'h24);

        // Branch overrides stall and interrupt
        load_pc(32'h40);
        bus.br_taken = 1; bus.br_target = 32'h100; bus.stall = 1; bus.int_req = 1;
        #1;
        chk("br_pc_src", bus.pc_src, 1);
        chk("br_ext", bus.ext_addr, 32'h100);
        chk("br_flush", bus.flush, 1);
        chk("br_no_rd", bus.dmem_rd, 0);
        tick();
        bus.br_taken = 0; bus.stall = 0;
        // Interrupt still pending: taken now with EPC = branch target
        #1;
        chk("br_pc", pcr, 32'h100);
        chk("bint_flush", bus.flush, 1);
        chk("bint_ext", bus.ext_addr, 32'h100);
        tick();
        bus.int_req = 0; bus.dmem_rdata = 32'h300;
        #1;
        chk("bint_rd", bus.dmem_rd, 1);
        chk("bint_epc", bus.epc, 32'h100);
        tick();
        chk("bint_ack", bus.int_ack, 1);
        chk("bint_vec", bus.ext_addr, 32'h300);
        tick();
        chk("bint_pc", pcr, 32'h300);
        bus.rti = 1; #1;
        chk("bint_rti", bus.ext_addr, 32'h100);
        tick(); bus.rti = 0;

        // Stall holds PC for 3 cycles
        load_pc(32'h30);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_pc_src", bus.pc_src, 1);
            chk("st_ext", bus.ext_addr, 32'h30);
            chk("st_flush", bus.flush, 0);
            tick();
            chk("st_pc", pcr, 32'h30);
        end
        bus.stall = 0;

        // Interrupt entry
        load_pc(32'h50);
        bus.int_req = 1; #1;
        chk("ie_acc_src", bus.pc_src, 1);
        chk("ie_acc_flush", bus.flush, 1);
        chk("ie_acc_ext", bus.ext_addr, 32'h50);
        chk("ie_acc_rd", bus.dmem_rd, 0);
        tick();
        bus.int_req = 0; bus.stall = 1; bus.dmem_rdata = 32'h200; #1;
        chk("ie_rd", bus.dmem_rd, 1);
        chk("ie_rd_addr", bus.dmem_addr, 32'h0);
        chk("ie_rd_ext", bus.ext_addr, 32'h50);
        chk("ie_rd_flush", bus.flush, 1);
        chk("ie_rd_ack", bus.int_ack, 0);
        chk("ie_hold1", pcr, 32'h50);
        tick(); #1;
        chk("ie_jmp_ext", bus.ext_addr, 32'h200);
        chk("ie_jmp_ack", bus.int_ack, 1);
        chk("ie_jmp_flush", bus.flush, 1);
        chk("ie_jmp_rd", bus.dmem_rd, 0);
        chk("ie_hold2", pcr, 32'h50);
        tick();
        bus.stall = 0; #1;
        chk("ie_pc", pcr, 32'h200);
        chk("ie_epc", bus.epc, 32'h50);
        chk("ie_ack_off", bus.int_ack, 0);
        bus.int_req = 1; #1;
        chk("ie_nonest", bus.pc_src, 0);
        tick(); #1;
        chk("ie_nonest2", bus.flush, 0);
        bus.rti = 1; #1;
        chk("rti_ext", bus.ext_addr, 32'h50);
        chk("rti_flush", bus.flush, 1);
        tick();
        bus.rti = 0; #1;
        // int_en restored: pending request accepted immediately
        chk("rti_pc", pcr, 32'h50);
        chk("re_acc_flush", bus.flush, 1);
        tick();
        bus.int_req = 0; #1;
        chk("re_rd", bus.dmem_rd, 1);

        // Reset in INT_RD aborts entry
        reset = 1; #1;
        chk("mr_rd", bus.dmem_rd, 0);
        chk("mr_src", bus.pc_src, 0);
        tick();
        reset = 0; #1;
        chk("mr_ack", bus.int_ack, 0);
        chk("mr_rd2", bus.dmem_rd, 0);
        chk("mr_epc", bus.epc, 0);
        tick(); #1;
        chk("mr_ack2", bus.int_ack, 0);
        bus.int_req = 1; #1;
        chk("mr_accept", bus.flush, 1);
        tick();
        bus.int_req = 0; #1;
        chk("mr_rd3", bus.dmem_rd, 1);
        tick(); tick();

        // Redirect alignment
        load_pc(32'h60);
        bus.br_taken = 1; bus.br_target = 32'h101; #1;
`ifdef PC_CTRL_ALIGN_CHK_EN
        chk("al_ext", bus.ext_addr, 32'h100);
        chk("al_err", bus.align_err, 1);
`else
        chk("al_ext", bus.ext_addr, 32'h101);
        chk("al_err", bus.align_err, 0);
`endif
        bus.br_target = 32'h102; #1;
        chk("al_ok_ext", bus.ext_addr, 32'h102);
        chk("al_ok_err", bus.align_err, 0);
        tick();
        bus.br_taken = 0; #1;
        chk("al_idle_err", bus.align_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
